// File: rtl/asteroide_uc.sv
// asteroide_uc -- Moore control unit for the asteroide datapath.
//
// Once per game tick it sweeps every asteroid slot through the slot counter,
// skips empty or destroyed slots, moves each live asteroid one cell in the
// direction given by its 2-bit opcode, writes it back to asteroid memory and
// checks for a ship collision right after the write.
//
// Optional feature (macro ASTEROIDE_UC_VIDAS_EN):
//   undefined : the first collision ends the game, load memory is never written.
//   defined   : each collision marks the slot destroyed and bumps a 2-bit hit
//               counter; the game ends only when hits reach VIDAS.
//
// Parameters
//   N_SLOTS  slot count (modulus of the datapath slot counter)
//   VIDAS    collisions tolerated before game over (feature build only)
//
// Ports
//   clock, reset           rising-edge clock, async active-high reset
//   iniciar, tick          start pulse / 1-cycle movement pulse from game timer
//   colisao, rco_contador  datapath status: ship hit, counter on last slot
//   opcode, loaded,
//   destruido              datapath status of the current slot
//   conta_contador .. new_destruido   datapath controls
//   pronto                 1-cycle pulse at the end of a sweep
//   fim_jogo               level, high while the game is over
//   db_estado              current state encoding, debug
module asteroide_uc #(
  parameter int N_SLOTS = 16,
  parameter int VIDAS   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tick,
  input  logic       colisao,
  input  logic       rco_contador,
  input  logic [1:0] opcode,
  input  logic       loaded,
  input  logic       destruido,
  output logic       conta_contador,
  output logic       reset_cont,
  output logic       reset_reg_nave,
  output logic       enable_reg_nave,
  output logic [1:0] select_mux_pos,
  output logic       select_mux_coor,
  output logic       select_soma_sub,
  output logic       enable_mem_aste,
  output logic       enable_mem_load,
  output logic       new_load,
  output logic       new_destruido,
  output logic       pronto,
  output logic       fim_jogo,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'h0,
    PREPARA   = 4'h1,
    ESPERA    = 4'h2,
    LE        = 4'h3,
    AVALIA    = 4'h4,
    MOVE      = 4'h5,
    CHECA     = 4'h6,
    PROXIMO   = 4'h7,
    FIM_VARRE = 4'h8,
    COLIDIU   = 4'h9,
    FIM_JOGO  = 4'hA
  } estado_t;

  estado_t    estado_q, estado_d;
  logic       tick_pend_q, tick_pend_d;
  // Opcode is captured in AVALIA so the MOVE controls come from registers
  // only and the outputs stay a pure function of state.
  logic [1:0] op_q, op_d;

  // The slot count only matters to the datapath counter; VIDAS is only
  // consumed by the optional hit counter.
  logic unused_cfg;
  assign unused_cfg = (N_SLOTS > 0) ^ (VIDAS > 0);

`ifdef ASTEROIDE_UC_VIDAS_EN
  localparam logic [1:0] VIDAS_L = 2'(VIDAS);
  logic [1:0] hits_q, hits_d;
  logic [1:0] hits_inc;
  assign hits_inc = hits_q + 2'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hits_q <= '0;
    else       hits_q <= hits_d;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q    <= INICIAL;
      tick_pend_q <= 1'b0;
      op_q        <= '0;
    end else begin
      estado_q    <= estado_d;
      tick_pend_q <= tick_pend_d;
      op_q        <= op_d;
    end
  end

  // Next state
  always_comb begin
    estado_d    = estado_q;
    tick_pend_d = tick_pend_q;
    op_d        = op_q;
`ifdef ASTEROIDE_UC_VIDAS_EN
    hits_d      = hits_q;
`endif
    // Ticks arriving mid-sweep collapse into one pending request; ticks
    // are meaningless before the game starts or after it ends.
    if (tick && estado_q != INICIAL && estado_q != FIM_JOGO)
      tick_pend_d = 1'b1;

    case (estado_q)
      INICIAL:   if (iniciar) estado_d = PREPARA;
      PREPARA: begin
        estado_d = ESPERA;
`ifdef ASTEROIDE_UC_VIDAS_EN
        hits_d   = '0;
`endif
      end
      ESPERA: begin
        if (tick_pend_q) begin
          estado_d    = LE;
          // consume the request; a tick landing this very cycle is kept
          tick_pend_d = tick;
        end
      end
      LE:        estado_d = AVALIA;
      AVALIA: begin
        op_d     = opcode;
        estado_d = (!loaded || destruido) ? PROXIMO : MOVE;
      end
      MOVE:      estado_d = CHECA;
      CHECA:     estado_d = colisao ? COLIDIU : PROXIMO;
      // The bumped counter is the memory read address, so the next slot is
      // evaluated straight away: two cycles per empty slot, four per live
      // one, which makes a sweep 2*N_SLOTS + 2*k + 1 cycles from LE.
      PROXIMO:   estado_d = rco_contador ? FIM_VARRE : AVALIA;
      FIM_VARRE: estado_d = ESPERA;
      COLIDIU: begin
`ifdef ASTEROIDE_UC_VIDAS_EN
        hits_d   = hits_inc;
        estado_d = (hits_inc == VIDAS_L) ? FIM_JOGO : PROXIMO;
`else
        estado_d = FIM_JOGO;
`endif
      end
      FIM_JOGO:  if (iniciar) estado_d = PREPARA;
      default:   estado_d = INICIAL;
    endcase
  end

  // Moore output decode: state and op_q only
  always_comb begin
    conta_contador  = 1'b0;
    reset_cont      = 1'b0;
    reset_reg_nave  = 1'b0;
    enable_reg_nave = 1'b0;
    select_mux_pos  = 2'b00;
    select_mux_coor = 1'b0;
    select_soma_sub = 1'b0;
    enable_mem_aste = 1'b0;
    enable_mem_load = 1'b0;
    new_load        = 1'b0;
    new_destruido   = 1'b0;
    pronto          = 1'b0;
    fim_jogo        = 1'b0;
    db_estado       = estado_q;

    case (estado_q)
      INICIAL: begin
        reset_cont     = 1'b1;
        reset_reg_nave = 1'b1;
      end
      PREPARA: begin
        reset_cont      = 1'b1;
        enable_reg_nave = 1'b1;
      end
      MOVE: begin
        // op[1] picks the axis, op[0] the direction
        enable_mem_aste = 1'b1;
        select_mux_coor = op_q[1];
        select_soma_sub = op_q[0];
        select_mux_pos  = op_q[1] ? 2'b10 : 2'b01;
      end
      // Also high on the last slot; the wrap is harmless since FIM_VARRE
      // clears the counter next.
      PROXIMO:   conta_contador = 1'b1;
      FIM_VARRE: begin
        pronto     = 1'b1;
        reset_cont = 1'b1;
      end
`ifdef ASTEROIDE_UC_VIDAS_EN
      COLIDIU: begin
        enable_mem_load = 1'b1;
        new_load        = 1'b1;
        new_destruido   = 1'b1;
      end
`endif
      FIM_JOGO: begin
        fim_jogo   = 1'b1;
        reset_cont = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_asteroide_uc.sv
// Directed bench for asteroide_uc with a behavioural datapath (slot counter,
// asteroid/load memory, ship register) around it. Expected sweep latencies
// are queued when a tick is issued and checked when pronto appears.
module tb_asteroide_uc;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] op;
    logic       ld;
    logic       ds;
  } slot_t;

  localparam logic [3:0] S_INICIAL = 4'h0, S_ESPERA = 4'h2, S_LE = 4'h3,
                         S_MOVE = 4'h5, S_FIM_JOGO = 4'hA;

  logic       clock = 1'b0, reset = 1'b0, iniciar = 1'b0, tick = 1'b0;
  logic       colisao, rco_contador, loaded, destruido;
  logic [1:0] opcode;
  logic       conta_contador, reset_cont, reset_reg_nave, enable_reg_nave;
  logic [1:0] select_mux_pos;
  logic       select_mux_coor, select_soma_sub, enable_mem_aste, enable_mem_load;
  logic       new_load, new_destruido, pronto, fim_jogo;
  logic [3:0] db_estado;

  asteroide_uc #(.N_SLOTS(16), .VIDAS(3)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .tick(tick),
    .colisao(colisao), .rco_contador(rco_contador), .opcode(opcode),
    .loaded(loaded), .destruido(destruido),
    .conta_contador(conta_contador), .reset_cont(reset_cont),
    .reset_reg_nave(reset_reg_nave), .enable_reg_nave(enable_reg_nave),
    .select_mux_pos(select_mux_pos), .select_mux_coor(select_mux_coor),
    .select_soma_sub(select_soma_sub), .enable_mem_aste(enable_mem_aste),
    .enable_mem_load(enable_mem_load), .new_load(new_load),
    .new_destruido(new_destruido), .pronto(pronto), .fim_jogo(fim_jogo),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // ---------------- datapath model ----------------
  slot_t      mem [16];
  logic [3:0] cnt, shx, shy;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_idx = 4'd0;
  slot_t      cfg_val = '0;
  int         wr_cnt = 0;
  slot_t      cur;
  logic [3:0] coord, sum;

  assign cur          = mem[cnt];
  assign loaded       = cur.ld;
  assign destruido    = cur.ds;
  assign opcode       = cur.op;
  assign rco_contador = (cnt == 4'd15);
  assign colisao      = (cur.x == shx) && (cur.y == shy);
  assign coord        = select_mux_coor ? cur.y : cur.x;
  assign sum          = select_soma_sub ? coord - 4'd1 : coord + 4'd1;

  always @(posedge clock) begin
    if (reset_cont)          cnt <= 4'd0;
    else if (conta_contador) cnt <= cnt + 4'd1;
    if (reset_reg_nave) begin
      shx <= 4'd0; shy <= 4'd0;
    end else if (enable_reg_nave) begin
      shx <= 4'd7; shy <= 4'd7;
    end
    if (cfg_we) mem[cfg_idx] <= cfg_val;
    else begin
      if (enable_mem_aste) begin
        if (select_mux_pos == 2'b01) mem[cnt].x <= sum;
        if (select_mux_pos == 2'b10) mem[cnt].y <= sum;
        wr_cnt <= wr_cnt + 1;
      end
      if (enable_mem_load) begin
        mem[cnt].ld <= new_load;
        mem[cnt].ds <= new_destruido;
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;
  int exp_q[$];
  int cyc = 0, le_cyc = 0, sweeps = 0, prontos = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor: timestamps LE entry, scores every pronto against the queue.
  initial begin
    logic [3:0] prev;
    prev = 4'h0;
    forever begin
      @(negedge clock);
      cyc++;
      if (db_estado == S_LE && prev != S_LE) begin
        le_cyc = cyc;
        sweeps++;
      end
      if (pronto === 1'b1) begin
        prontos++;
        if (exp_q.size() == 0) chk("pronto_unexpected", 1, 0);
        else chk("sweep_latency", cyc - le_cyc, exp_q.pop_front());
      end
      prev = db_estado;
    end
  end

  function automatic slot_t mk(input int x, input int y, input int op, input bit ld);
    slot_t s;
    s.x = 4'(x); s.y = 4'(y); s.op = 2'(op); s.ld = ld; s.ds = 1'b0;
    return s;
  endfunction

  task automatic put(input int idx, input slot_t v);
    cfg_idx = 4'(idx); cfg_val = v; cfg_we = 1'b1;
    @(negedge clock);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; @(negedge clock); tick = 1'b0;
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1; @(negedge clock); iniciar = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (db_estado !== s && n < budget) begin
      @(negedge clock); n++;
    end
    chk(tag, int'(db_estado), int'(s));
  endtask

  // Wait for every queued sweep to report pronto; an expired budget fails.
  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock); n++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clock);
  endtask

  function automatic int ctrl_vec();
    return int'({conta_contador, reset_cont, reset_reg_nave, enable_reg_nave,
                 select_mux_pos, select_mux_coor, select_soma_sub,
                 enable_mem_aste, enable_mem_load, new_load, new_destruido,
                 pronto, fim_jogo});
  endfunction

  initial begin
    int w0, s0, p0;
    #2 reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 16; i++) put(i, '0);

    // reset state: only reset_cont and reset_reg_nave high
    chk("reset_state", int'(db_estado), int'(S_INICIAL));
    chk("reset_outputs", ctrl_vec(), 'b01100000000000);
    chk("reset_pend", int'(dut.tick_pend_q), 0);

    // tick in INICIAL is dropped when it coincides with iniciar
    put(0, mk(7, 0, 1, 1'b1));
    reset = 1'b0;
    @(negedge clock);
    tick = 1'b1; iniciar = 1'b1; @(negedge clock); tick = 1'b0; iniciar = 1'b0;
    repeat (3) @(negedge clock);
    chk("start_espera", int'(db_estado), int'(S_ESPERA));
    chk("tick_dropped", sweeps, 0);

    // slot 0 (7,0) op 01 -> X-1
    w0 = wr_cnt;
    exp_q.push_back(35);
    pulse_tick();
    wait_state(S_MOVE, 20, "move_a_reach");
    chk("move_a_ctrl", {select_mux_pos, select_mux_coor, select_soma_sub, enable_mem_aste}, 'b01011);
    wait_idle(200, "sweep_a_done");
    chk("a_x", int'(mem[0].x), 6);
    chk("a_y", int'(mem[0].y), 0);
    chk("a_writes", wr_cnt - w0, 1);

    // same slot, op 10 -> Y+1
    put(0, mk(6, 0, 2, 1'b1));
    w0 = wr_cnt;
    exp_q.push_back(35);
    pulse_tick();
    wait_state(S_MOVE, 20, "move_b_reach");
    chk("move_b_ctrl", {select_mux_pos, select_mux_coor, select_soma_sub, enable_mem_aste}, 'b10101);
    wait_idle(200, "sweep_b_done");
    chk("b_xy", int'({mem[0].x, mem[0].y}), 'h61);
    chk("b_writes", wr_cnt - w0, 1);

    // wrap-around in both directions
    put(0, '0);
    put(1, mk(15, 3, 0, 1'b1));
    put(2, mk(4, 0, 3, 1'b1));
    w0 = wr_cnt;
    exp_q.push_back(37);
    pulse_tick();
    wait_idle(200, "sweep_wrap_done");
    chk("wrap_x", int'(mem[1].x), 0);
    chk("wrap_y", int'(mem[2].y), 15);
    chk("wrap_writes", wr_cnt - w0, 2);

    // empty field: extra ticks collapse, iniciar mid-sweep ignored
    put(1, '0);
    put(2, '0);
    w0 = wr_cnt; s0 = sweeps;
    exp_q.push_back(33);
    exp_q.push_back(33);
    pulse_tick();
    wait_state(S_LE, 10, "empty_le");
    repeat (3) @(negedge clock);
    pulse_tick();
    pulse_iniciar();
    pulse_tick();
    @(negedge clock);
    pulse_tick();
    wait_idle(300, "empty_sweeps_done");
    repeat (60) @(negedge clock);
    chk("empty_sweeps", sweeps - s0, 2);
    chk("empty_writes", wr_cnt - w0, 0);
    chk("empty_idle", int'(db_estado), int'(S_ESPERA));

    // async reset in the middle of MOVE: no write, sweep restarts at slot 0
    put(0, mk(7, 0, 1, 1'b1));
    w0 = wr_cnt;
    pulse_tick();
    wait_state(S_MOVE, 20, "rst_move_reach");
    #2 reset = 1'b1;
    #1 chk("rst_async_state", int'(db_estado), int'(S_INICIAL));
    chk("rst_async_we", int'(enable_mem_aste), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_no_write", wr_cnt - w0, 0);
    chk("rst_mem_kept", int'(mem[0].x), 7);
    pulse_iniciar();
    exp_q.push_back(35);
    pulse_tick();
    wait_idle(200, "rst_sweep_done");
    chk("rst_x", int'(mem[0].x), 6);
    chk("rst_writes", wr_cnt - w0, 1);

    // collision: (7,6) op 10 lands on the ship at (7,7)
    put(0, mk(7, 6, 2, 1'b1));
    p0 = prontos;
`ifdef ASTEROIDE_UC_VIDAS_EN
    exp_q.push_back(36);
    pulse_tick();
    wait_idle(200, "col_sweep_done");
    chk("col_destroyed", int'({mem[0].ld, mem[0].ds}), 3);
    chk("col_prontos", prontos - p0, 1);
    chk("col_no_gameover", int'(fim_jogo), 0);
`else
    pulse_tick();
    wait_state(S_FIM_JOGO, 100, "col_gameover_reach");
    repeat (40) @(negedge clock);
    chk("col_fim_jogo", int'(fim_jogo), 1);
    chk("col_reset_cont", int'(reset_cont), 1);
    chk("col_no_pronto", prontos - p0, 0);
    chk("col_y", int'(mem[0].y), 7);
    // tick ignored in FIM_JOGO; iniciar restarts without a sweep
    s0 = sweeps;
    pulse_tick();
    pulse_iniciar();
    repeat (40) @(negedge clock);
    chk("restart_espera", int'(db_estado), int'(S_ESPERA));
    chk("restart_no_sweep", sweeps - s0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

endmodule
